// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch stage: fetch payload, FSM states and
// next-PC select codes.
package fetch_unit_pkg;

    localparam int          XLEN_DEF         = 64;
    localparam logic [63:0] PC_RESET_DEFAULT = 64'h8000_0000;

    typedef logic [XLEN_DEF-1:0] addr_t;
    typedef logic [31:0]         word_t;

    typedef struct packed {
        logic  valid;
        addr_t pc;
        word_t instr;
        logic  misalign;
    } fetch_data_t;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DISCARD,
        S_HOLD
    } fetch_state_t;

    typedef enum logic [1:0] {
        PCSEL_KEEP,
        PCSEL_INC,
        PCSEL_REDIR
    } pc_sel_t;

endpackage

// File: rtl/fetch_unit_pcsel.sv
// Next-PC mux: keep the current PC, step to the next word, or take a redirect.
module fetch_unit_pcsel
    import fetch_unit_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  pc_sel_t           sel,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic [XLEN-1:0]   next_pc
);

    always_comb begin
        next_pc = pc;
        case (sel)
            PCSEL_INC:   next_pc = pc + XLEN'(4);
            PCSEL_REDIR: next_pc = redirect_pc;
            default:     next_pc = pc;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the fetch PC, runs the instruction-bus handshake and presents
// one fetch_data_t per cycle to the F/D register.
//
//  state     | meaning
//  S_REQ     | request at pc (or present misalign fault)
//  S_WAIT    | request accepted, awaiting data_ok
//  S_DISCARD | in-flight response belongs to a stale pc
//  S_HOLD    | instruction buffered while downstream stalls
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] PC_RESET = XLEN'(PC_RESET_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              stall,
    output logic              ireq_valid,
    output logic [XLEN-1:0]   ireq_addr,
    input  logic              iresp_addr_ok,
    input  logic              iresp_data_ok,
    input  logic [31:0]       iresp_data,
    output logic              fetch_valid,
    output logic [XLEN-1:0]   fetch_pc,
    output logic [31:0]       fetch_instr,
    output logic              fetch_misalign,
    output logic              fetch_busy
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    word_t           hold_q, hold_d;
    pc_sel_t         pc_sel;
    fetch_data_t     fetch_out;
    logic            aligned;
    logic            req_fire;
    logic            data_hit;

    always_comb begin
        aligned  = (pc_q[1:0] == 2'b00);
        req_fire = (state_q == S_REQ) && aligned && iresp_addr_ok;
        // addr_ok and data_ok together in REQ is a zero-wait response
        data_hit = iresp_data_ok && ((state_q == S_WAIT) || req_fire);
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pc_sel  = PCSEL_KEEP;
        if (redirect_valid) begin
            pc_sel = PCSEL_REDIR;
            case (state_q)
                S_REQ:     state_d = (req_fire && !iresp_data_ok) ? S_DISCARD : S_REQ;
                S_WAIT:    state_d = iresp_data_ok ? S_REQ : S_DISCARD;
                S_DISCARD: state_d = iresp_data_ok ? S_REQ : S_DISCARD;
                default:   state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ, S_WAIT: begin
                    if (data_hit) begin
                        if (stall) begin
                            hold_d  = iresp_data;
                            state_d = S_HOLD;
                        end else begin
                            pc_sel  = PCSEL_INC;
                            state_d = S_REQ;
                        end
                    end else if (req_fire) begin
                        state_d = S_WAIT;
                    end
                end
                S_DISCARD: begin
                    if (iresp_data_ok) state_d = S_REQ;
                end
                default: begin
                    if (!stall) begin
                        pc_sel  = PCSEL_INC;
                        state_d = S_REQ;
                    end
                end
            endcase
        end
    end

    fetch_unit_pcsel #(
        .XLEN (XLEN)
    ) u_pcsel (
        .sel         (pc_sel),
        .pc          (pc_q),
        .redirect_pc (redirect_pc),
        .next_pc     (pc_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= PC_RESET;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        fetch_out    = '0;
        fetch_out.pc = addr_t'(pc_q);
        ireq_valid   = !reset && (state_q == S_REQ) && aligned;
        if (!reset && !redirect_valid) begin
            case (state_q)
                S_REQ: begin
                    if (!aligned) begin
                        fetch_out.valid    = 1'b1;
                        fetch_out.misalign = 1'b1;
                    end else if (data_hit) begin
                        fetch_out.valid = 1'b1;
                        fetch_out.instr = iresp_data;
                    end
                end
                S_WAIT: begin
                    if (iresp_data_ok) begin
                        fetch_out.valid = 1'b1;
                        fetch_out.instr = iresp_data;
                    end
                end
                S_HOLD: begin
                    fetch_out.valid = 1'b1;
                    fetch_out.instr = hold_q;
                end
                default: ;
            endcase
        end
    end

    assign ireq_addr      = pc_q;
    assign fetch_valid    = fetch_out.valid;
    assign fetch_pc       = XLEN'(fetch_out.pc);
    assign fetch_instr    = fetch_out.instr;
    assign fetch_misalign = fetch_out.misalign;
    assign fetch_busy     = !fetch_out.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle vectors with a scoreboard for the
// presented fetch_data_t.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        stall;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        fetch_valid;
    logic [63:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        fetch_misalign;
    logic        fetch_busy;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rst;
        logic        redir;
        logic [63:0] rpc;
        logic        stall;
        logic        aok;
        logic        dok;
        logic [31:0] data;
        logic        e_iv;
        logic [63:0] e_addr;
        logic        e_fv;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
        logic        e_mis;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[$];

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_addr_ok  (iresp_addr_ok),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .fetch_instr    (fetch_instr),
        .fetch_misalign (fetch_misalign),
        .fetch_busy     (fetch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic rst, input logic redir, input logic [63:0] rpc,
        input logic stl, input logic aok, input logic dok, input logic [31:0] data,
        input logic e_iv, input logic [63:0] e_addr, input logic e_fv,
        input logic [63:0] e_pc, input logic [31:0] e_instr, input logic e_mis);
        vec_t v;
        v.rst = rst;   v.redir = redir; v.rpc = rpc;   v.stall = stl;
        v.aok = aok;   v.dok = dok;     v.data = data;
        v.e_iv = e_iv; v.e_addr = e_addr; v.e_fv = e_fv;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        reset          = v.rst;
        redirect_valid = v.redir;
        redirect_pc    = v.rpc;
        stall          = v.stall;
        iresp_addr_ok  = v.aok;
        iresp_data_ok  = v.dok;
        iresp_data     = v.data;
        #1;
        if (v.e_fv) begin
            e.pc = v.e_pc; e.instr = v.e_instr; e.mis = v.e_mis;
            exp_q.push_back(e);
        end
        chk({tag, ".ireq_valid"}, 64'(ireq_valid), 64'(v.e_iv));
        if (v.e_iv) chk({tag, ".ireq_addr"}, ireq_addr, v.e_addr);
        chk({tag, ".fetch_valid"}, 64'(fetch_valid), 64'(v.e_fv));
        chk({tag, ".fetch_busy"}, 64'(fetch_busy), 64'(!v.e_fv));
        if (fetch_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, ".fetch_pc"}, fetch_pc, e.pc);
            chk({tag, ".fetch_instr"}, 64'(fetch_instr), 64'(e.instr));
            chk({tag, ".fetch_misalign"}, 64'(fetch_misalign), 64'(e.mis));
        end
        exp_q.delete();
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        stall          = 1'b0;
        iresp_addr_ok  = 1'b0;
        iresp_data_ok  = 1'b0;
        iresp_data     = '0;

        // reset, zero-wait stream, then a wrap at the top of the address space
        tbl.push_back(mk(1,0,64'h0,0,0,0,32'h0, 0,64'h0,0,64'h0,32'h0,0));
        tbl.push_back(mk(1,0,64'h0,0,1,1,32'h13, 0,64'h0,0,64'h0,32'h0,0));
        tbl.push_back(mk(0,0,64'h0,0,1,1,32'h13, 1,64'h8000_0000,1,64'h8000_0000,32'h13,0));
        tbl.push_back(mk(0,0,64'h0,0,1,1,32'h13, 1,64'h8000_0004,1,64'h8000_0004,32'h13,0));
        tbl.push_back(mk(0,0,64'h0,0,1,1,32'h13, 1,64'h8000_0008,1,64'h8000_0008,32'h13,0));
        tbl.push_back(mk(0,0,64'h0,0,0,0,32'h0, 1,64'h8000_000c,0,64'h0,32'h0,0));
        tbl.push_back(mk(0,1,64'hFFFF_FFFF_FFFF_FFFC,0,0,0,32'h0, 1,64'h8000_000c,0,64'h0,32'h0,0));
        tbl.push_back(mk(0,0,64'h0,0,1,1,32'h0010_0093, 1,64'hFFFF_FFFF_FFFF_FFFC,1,64'hFFFF_FFFF_FFFF_FFFC,32'h0010_0093,0));
        tbl.push_back(mk(0,0,64'h0,0,0,0,32'h0, 1,64'h0,0,64'h0,32'h0,0));
        foreach (tbl[i]) apply_vec(tbl[i], $sformatf("tbl%0d", i));

        // latency 3 with stall on data_ok -> HOLD, then release
        apply_vec(mk(1,0,64'h0,0,0,0,32'h0, 0,64'h0,0,64'h0,32'h0,0), "t2.rst");
        apply_vec(mk(1,0,64'h0,0,0,0,32'h0, 0,64'h0,0,64'h0,32'h0,0), "t2.rst");
        apply_vec(mk(0,0,64'h0,0,1,0,32'h0, 1,64'h8000_0000,0,64'h0,32'h0,0), "t2.req");
        apply_vec(mk(0,0,64'h0,0,0,0,32'h0, 0,64'h0,0,64'h0,32'h0,0), "t2.wait1");
        apply_vec(mk(0,0,64'h0,0,0,0,32'h0, 0,64'h0,0,64'h0,32'h0,0), "t2.wait2");
        apply_vec(mk(0,0,64'h0,1,0,1,32'h13, 0,64'h0,1,64'h8000_0000,32'h13,0), "t2.data");
        apply_vec(mk(0,0,64'h0,1,0,0,32'h0, 0,64'h0,1,64'h8000_0000,32'h13,0), "t2.hold1");
        apply_vec(mk(0,0,64'h0,0,0,0,32'h0, 0,64'h0,1,64'h8000_0000,32'h13,0), "t2.hold2");
        apply_vec(mk(0,0,64'h0,0,0,0,32'h0, 1,64'h8000_0004,0,64'h0,32'h0,0), "t2.next");

        // redirect in WAIT, second redirect in DISCARD, stale data dropped
        apply_vec(mk(0,0,64'h0,0,1,0,32'h0, 1,64'h8000_0004,0,64'h0,32'h0,0), "t3.req");
        apply_vec(mk(0,1,64'h8000_0800,0,0,0,32'h0, 0,64'h0,0,64'h0,32'h0,0), "t3.redir");
        apply_vec(mk(0,1,64'h8000_1000,0,0,0,32'h0, 0,64'h0,0,64'h0,32'h0,0), "t3.redir2");
        apply_vec(mk(0,0,64'h0,0,0,1,32'hdead_beef, 0,64'h0,0,64'h0,32'h0,0), "t3.stale");
        apply_vec(mk(0,0,64'h0,0,0,0,32'h0, 1,64'h8000_1000,0,64'h0,32'h0,0), "t3.next");

        // redirect coincident with data_ok and stall: no HOLD
        apply_vec(mk(0,0,64'h0,0,1,0,32'h0, 1,64'h8000_1000,0,64'h0,32'h0,0), "t4.req");
        apply_vec(mk(0,1,64'h8000_2000,1,0,1,32'h0000_0113, 0,64'h0,0,64'h0,32'h0,0), "t4.redir");
        apply_vec(mk(0,0,64'h0,1,0,0,32'h0, 1,64'h8000_2000,0,64'h0,32'h0,0), "t4.next");

        // misaligned target: fault held, stall and bus ignored, until redirect
        apply_vec(mk(0,1,64'h8000_0002,0,0,0,32'h0, 1,64'h8000_2000,0,64'h0,32'h0,0), "t5.redir");
        apply_vec(mk(0,0,64'h0,1,0,0,32'h0, 0,64'h0,1,64'h8000_0002,32'h0,1), "t5.fault1");
        apply_vec(mk(0,0,64'h0,0,1,1,32'hdead_beef, 0,64'h0,1,64'h8000_0002,32'h0,1), "t5.fault2");
        apply_vec(mk(0,1,64'h8000_0010,0,0,0,32'h0, 0,64'h0,0,64'h0,32'h0,0), "t5.redir2");
        apply_vec(mk(0,0,64'h0,0,0,0,32'h0, 1,64'h8000_0010,0,64'h0,32'h0,0), "t5.next");

        // reset during WAIT, late data_ok ignored
        apply_vec(mk(0,0,64'h0,0,1,0,32'h0, 1,64'h8000_0010,0,64'h0,32'h0,0), "t6.req");
        apply_vec(mk(1,0,64'h0,0,0,0,32'h0, 0,64'h0,0,64'h0,32'h0,0), "t6.rst");
        apply_vec(mk(0,0,64'h0,0,0,1,32'hdead_beef, 1,64'h8000_0000,0,64'h0,32'h0,0), "t6.late");
        apply_vec(mk(0,0,64'h0,0,1,1,32'h13, 1,64'h8000_0000,1,64'h8000_0000,32'h13,0), "t6.first");
        apply_vec(mk(0,0,64'h0,0,0,0,32'h0, 1,64'h8000_0004,0,64'h0,32'h0,0), "t6.next");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
